// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types, default sizes and helpers for the multi-port
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    // An address is readable when it names a real entry and is not the
    // hard-wired zero register.
    function automatic logic addr_readable(input logic [31:0] addr,
                                           input int unsigned depth,
                                           input logic        zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One registered read port with write-through bypass,
//               zero-register / out-of-range masking and stall hold.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [AW-1:0]   i_raddr,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_wcommit,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic            w_valid;
    logic            w_hit;
    logic [XLEN-1:0] w_next;
    logic [XLEN-1:0] r_data;

    assign w_valid = addr_readable(32'(i_raddr), DEPTH, ZERO_REG != 0);
    assign w_hit   = i_wcommit && (i_waddr == i_raddr);

    // Masking wins over bypass so a masked address never leaks wdata.
    always_comb begin
        w_next = '0;
        if (w_valid) begin
            w_next = w_hit ? i_wdata : i_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_next;
        end
    end

    assign o_rdata = r_data;

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register file with a power-up clear sequence,
//               single write port and one-cycle registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int NREAD    = NREAD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  rd_en,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic                  ready
);

    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    logic [XLEN-1:0] r_mem [DEPTH];
    rf_state_t       r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;

    logic            w_wcommit;
    logic            w_rd_en;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_wdata;

    assign w_wcommit = (r_state == RUN) && we &&
                       addr_readable(32'(waddr), DEPTH, ZERO_REG != 0);
    assign w_rd_en   = (r_state == RUN) && rd_en;

    // The clear counter owns the write port until the sequence finishes.
    assign w_mem_we    = !rst && ((r_state == CLEAR) || w_wcommit);
    assign w_mem_addr  = (r_state == CLEAR) ? r_clr_idx : waddr;
    assign w_mem_wdata = (r_state == CLEAR) ? '0 : wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + AW'(1);
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_idx <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    generate
        for (genvar g = 0; g < NREAD; g++) begin : g_rd_port
            logic [AW-1:0]   w_raddr;
            logic [XLEN-1:0] w_mem_data;

            assign w_raddr    = raddr[g*AW +: AW];
            // Guard the array index; the port masks out-of-range reads anyway.
            assign w_mem_data = (32'(w_raddr) < 32'(DEPTH)) ? r_mem[w_raddr] : '0;

            regfile_rd_port #(
                .XLEN     (XLEN),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG)
            ) u_rd_port (
                .clk        (clk),
                .rst        (rst),
                .i_en       (w_rd_en),
                .i_raddr    (w_raddr),
                .i_mem_data (w_mem_data),
                .i_wcommit  (w_wcommit),
                .i_waddr    (waddr),
                .i_wdata    (wdata),
                .o_rdata    (rdata[g*XLEN +: XLEN])
            );
        end
    endgenerate

    assign ready = r_ready;

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (default sizing
//               plus a DEPTH=20 / NREAD=3 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: XLEN=32, DEPTH=32, NREAD=2, AW=5
    logic        rst, we, rd_en, ready;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    // Small instance: DEPTH=20, NREAD=3, AW=5
    logic        b_rst, b_we, b_rd_en, b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [14:0] b_raddr;
    logic [95:0] b_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_low;

    regfile_mp dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rd_en (rd_en),
        .raddr (raddr),
        .rdata (rdata),
        .ready (ready)
    );

    regfile_mp #(.XLEN(32), .DEPTH(20), .NREAD(3), .ZERO_REG(1)) dut20 (
        .clk   (clk),
        .rst   (b_rst),
        .we    (b_we),
        .waddr (b_waddr),
        .wdata (b_wdata),
        .rd_en (b_rd_en),
        .raddr (b_raddr),
        .rdata (b_rdata),
        .ready (b_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; rd_en = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        b_rst = 1'b1; b_we = 1'b0; b_rd_en = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;

        // ---------------- reset and clear sequence (default instance)
        step();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_rd0", rdata[31:0], 32'd0);
        chk("reset_rd1", rdata[63:32], 32'd0);

        // Accesses during CLEAR must be ignored.
        rst = 1'b0;
        we = 1'b1; waddr = 5'd2; wdata = 32'h1111_1111;
        rd_en = 1'b1; raddr = {5'd2, 5'd2};
        n_low = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            n_low++;
            step();
        end
        chk("clear_low_cycles", 32'(n_low), 32'd32);
        chk("clear_ready_high", {31'd0, ready}, 32'd1);
        chk("clear_rd0_zero", rdata[31:0], 32'd0);
        chk("clear_rd1_zero", rdata[63:32], 32'd0);

        // ---------------- RUN: post-clear contents are zero
        we = 1'b0; rd_en = 1'b1; raddr = {5'd9, 5'd2};
        step();
        chk("run_rd_a2", rdata[31:0], 32'd0);
        chk("run_rd_a9", rdata[63:32], 32'd0);

        // Write then read
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; rd_en = 1'b0;
        step();
        we = 1'b0; rd_en = 1'b1; raddr = {5'd5, 5'd5};
        step();
        chk("wr_rd_p0", rdata[31:0], 32'hDEAD_BEEF);
        chk("wr_rd_p1", rdata[63:32], 32'hDEAD_BEEF);

        // Same-cycle bypass on both ports
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; rd_en = 1'b1; raddr = {5'd7, 5'd7};
        step();
        chk("bypass_p0", rdata[31:0], 32'h1234_5678);
        chk("bypass_p1", rdata[63:32], 32'h1234_5678);

        we = 1'b0; raddr = {5'd5, 5'd7};
        step();
        chk("indep_p0", rdata[31:0], 32'h1234_5678);
        chk("indep_p1", rdata[63:32], 32'hDEAD_BEEF);

        // Zero register, bypass case then plain read
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
        step();
        chk("zero_byp_p0", rdata[31:0], 32'd0);
        chk("zero_byp_p1", rdata[63:32], 32'd0);
        we = 1'b0; raddr = {5'd7, 5'd0};
        step();
        chk("zero_rd_p0", rdata[31:0], 32'd0);
        chk("zero_rd_p1", rdata[63:32], 32'h1234_5678);

        // Stall
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5; rd_en = 1'b0;
        step();
        we = 1'b0; rd_en = 1'b1; raddr = {5'd5, 5'd9};
        step();
        chk("stall_load", rdata[31:0], 32'hA5A5_A5A5);
        rd_en = 1'b0;
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_F00D; raddr = {5'd7, 5'd7};
        step();
        chk("stall1_p0", rdata[31:0], 32'hA5A5_A5A5);
        waddr = 5'd5; wdata = 32'hCAFE_F00D; raddr = {5'd3, 5'd0};
        step();
        chk("stall2_p0", rdata[31:0], 32'hA5A5_A5A5);
        waddr = 5'd9; wdata = 32'h1357_2468; raddr = {5'd9, 5'd9};
        step();
        chk("stall3_p0", rdata[31:0], 32'hA5A5_A5A5);
        chk("stall3_p1", rdata[63:32], 32'hDEAD_BEEF);
        we = 1'b0; rd_en = 1'b1; raddr = {5'd5, 5'd9};
        step();
        chk("post_stall_p0", rdata[31:0], 32'h1357_2468);
        chk("post_stall_p1", rdata[63:32], 32'hCAFE_F00D);
        rd_en = 1'b0;

        // ---------------- DEPTH=20, NREAD=3 instance
        b_rst = 1'b0;
        n_low = 0;
        for (int i = 0; i < 40 && !b_ready; i++) begin
            n_low++;
            step();
        end
        chk("d20_clear_low", 32'(n_low), 32'd20);

        // RUN cycles 1..9
        b_we = 1'b1; b_waddr = 5'd3; b_wdata = 32'h3333_3333;
        step();
        b_waddr = 5'd19; b_wdata = 32'h1919_1919;
        step();
        b_waddr = 5'd25; b_wdata = 32'hEEEE_EEEE;
        b_rd_en = 1'b1; b_raddr = {5'd20, 5'd19, 5'd25};
        step();
        chk("d20_oor25_byp", b_rdata[31:0], 32'd0);
        chk("d20_last_idx", b_rdata[63:32], 32'h1919_1919);
        chk("d20_oor20", b_rdata[95:64], 32'd0);
        b_we = 1'b0; b_raddr = {5'd3, 5'd3, 5'd3};
        step();
        chk("d20_same_p0", b_rdata[31:0], 32'h3333_3333);
        chk("d20_same_p1", b_rdata[63:32], 32'h3333_3333);
        chk("d20_same_p2", b_rdata[95:64], 32'h3333_3333);
        b_we = 1'b1; b_waddr = 5'd4; b_wdata = 32'h4444_4444; b_rd_en = 1'b0;
        step();
        b_we = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // RUN cycle 10: reset with a concurrent write and read
        b_rst = 1'b1; b_we = 1'b1; b_waddr = 5'd4; b_wdata = 32'h5555_5555;
        b_rd_en = 1'b1; b_raddr = {5'd4, 5'd4, 5'd4};
        step();
        chk("d20_rst_ready", {31'd0, b_ready}, 32'd0);
        chk("d20_rst_rdata", b_rdata[31:0] | b_rdata[63:32] | b_rdata[95:64], 32'd0);
        b_rst = 1'b0; b_we = 1'b0; b_rd_en = 1'b0;
        n_low = 0;
        for (int i = 0; i < 40 && !b_ready; i++) begin
            n_low++;
            step();
        end
        chk("d20_reclear_low", 32'(n_low), 32'd20);
        b_rd_en = 1'b1; b_raddr = {5'd4, 5'd25, 5'd3};
        step();
        chk("d20_a3_cleared", b_rdata[31:0], 32'd0);
        chk("d20_a25_zero", b_rdata[63:32], 32'd0);
        chk("d20_a4_cleared", b_rdata[95:64], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
